// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter with built-in baud divider,
// valid/ready input handshake and a transmit buffer, all in the clk domain.
//
// Optional feature macro: UART_TX_STREAM_FIFO_EN
//   defined     -> FIFO of FIFO_DEPTH entries buffers input words
//   not defined -> a single holding register buffers one word
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   producer offers in_data
//   in_ready   out  a word is accepted this cycle if in_valid is also high
//   in_data    in   DATA_BITS payload, sent LSB first
//   tx         out  registered serial line, idle high
//   busy       out  frame in progress or data buffered
//   fifo_count out  words buffered and not yet started
module uart_tx_stream #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_BITS-1:0]               in_data,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int DIV = CLK_FREQ / BAUD;
    // Counter must reach the longest interval, the stop period.
    localparam int CW  = $clog2(STOP_BITS * DIV + 1);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(DATA_BITS - 1);

    // PAR is the parity-bit state (the name PARITY is taken by the parameter).
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic                 push, pop, empty, full;
    logic [DATA_BITS-1:0] head;

    assign push     = in_valid && in_ready;
    // No push-through on pop: a full buffer refuses the word even if the
    // FSM pops in the same cycle.
    assign in_ready = rst_n && !full;

`ifdef UART_TX_STREAM_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [NW-1:0]        count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: ;
            endcase
        end
    end

    assign full       = (count == NW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
`else
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold;

    // push needs !hold_full and pop needs hold_full, so they never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n)
            hold_full <= 1'b0;
        else if (push)
            hold_full <= 1'b1;
        else if (pop)
            hold_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            hold <= in_data;
    end

    assign full       = hold_full;
    assign empty      = !hold_full;
    assign head       = hold;
    assign fifo_count = NW'(hold_full);
`endif

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 tx_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            par_bit <= par_n;
            tx      <= tx_n;
        end
    end

    // tx is registered: tx_n is the line level for the state being entered,
    // so the line changes on the same edge as the state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        par_n   = par_bit;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = (PARITY == 1) ? ~^head : ^head;
                    idx_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = DATA;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    idx_n   = idx + 4'd1;
                    tx_n    = shift_n[0];
                    if (idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_n = PAR;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end
                end
            end
            PAR: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                // Return to IDLE for one cycle even with data waiting.
                if (cnt == STOP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream. Four instances at DIV=16:
//   0: 8N1 (buffer/reset tests), 1: 7E1, 2: 7O1, 3: 8N2.
// Accepted words go into a scoreboard queue; each observed frame pops one
// entry and is compared cycle by cycle against a line model built from it.
module tb_uart_tx_stream;
    localparam int BIT    = 16;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] vld, rdy, txv, bsy;
    logic [7:0] dat [4];
    logic [2:0] fc  [4];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dbits(input int i);
        return (i == 1 || i == 2) ? 7 : 8;
    endfunction
    function automatic int pmode(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int stops(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic logic [7:0] msk(input int i);
        return (dbits(i) == 7) ? 8'h7f : 8'hff;
    endfunction

    uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut (.clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
           .tx(txv[0]), .busy(bsy[0]), .fifo_count(fc[0]));
    uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_par (.clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1][6:0]),
           .tx(txv[1]), .busy(bsy[1]), .fifo_count(fc[1]));
    uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_odd (.clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(dat[2][6:0]),
           .tx(txv[2]), .busy(bsy[2]), .fifo_count(fc[2]));
    uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_stop (.clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(dat[3]),
            .tx(txv[3]), .busy(bsy[3]), .fifo_count(fc[3]));

    // Inputs change #1 after posedge, so at negedge valid&&ready predicts
    // an acceptance on the coming posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (vld[i] && rdy[i])
                exp_q.push_back('{i, dat[i] & msk(i)});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers d to instance i; e returns the accepting edge number.
    task automatic push(input int i, input logic [7:0] d, output int e);
        int n = 0;
        @(posedge clk); #1;
        vld[i] = 1'b1;
        dat[i] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[i] && n < BUDGET);
        if (!rdy[i]) begin
            chk("push_timeout", 0, 1);
            e = -1;
        end else begin
            e = cyc + 1;
        end
        @(posedge clk); #1;
        vld[i] = 1'b0;
    endtask

    // Waits for a start bit on instance i, pops the expected word and checks
    // every cycle of the frame. f = edge of the falling start bit,
    // pb = parity bit sampled mid-bit. Returns at the negedge of the last
    // frame cycle.
    task automatic rx_frame(input int i, output int f, output logic pb);
        int          n = 0;
        int          nb;
        int          db;
        int          errs = 0;
        exp_t        e;
        logic [7:0]  got = '0;
        logic [7:0]  d;
        logic [15:0] lb = '0;
        pb = 1'b0;
        f  = -1;
        do begin
            @(negedge clk);
            n++;
        end while (txv[i] !== 1'b0 && n < BUDGET);
        if (txv[i] !== 1'b0) begin
            chk("rx_start_timeout", 0, 1);
            return;
        end
        f = cyc;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_idx", i, e.idx);
        db = dbits(i);
        d  = e.data;
        lb[0] = 1'b0;
        for (int k = 0; k < db; k++) lb[1+k] = d[k];
        nb = 1 + db;
        if (pmode(i) != 0) begin
            lb[nb] = (pmode(i) == 1) ? ~^d : ^d;
            nb = nb + 1;
        end
        for (int s = 0; s < stops(i); s++) begin
            lb[nb] = 1'b1;
            nb = nb + 1;
        end
        for (int c = 0; c < nb * BIT; c++) begin
            if (c > 0) @(negedge clk);
            if (txv[i] !== lb[c/BIT]) errs++;
            if (c % BIT == BIT / 2) begin
                if (c / BIT >= 1 && c / BIT <= db) got[c/BIT-1] = txv[i];
                if (pmode(i) != 0 && c / BIT == db + 1) pb = txv[i];
            end
        end
        chk("line_errs", errs, 0);
        chk("rx_data", got, d);
    endtask

    initial begin
        int   e, e1, e2, e3, f, f1, f2, f3, n, acc, lows, nbuf;
        logic pb;
        vld = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        e2 = 0; e3 = 0; f3 = 0; acc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", txv[i], 1);
            chk("rst_busy", bsy[i], 0);
            chk("rst_fc", fc[i], 0);
            chk("rst_rdy", rdy[i], 0);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) chk("rdy_after_rst", rdy[i], 1);

        // 8N1, 0x2A: latency, line pattern, busy fall at E+161
        push(0, 8'h2A, e);
        @(negedge clk);
        chk("fc_after_push", fc[0], 1);
        rx_frame(0, f, pb);
        chk("start_lat", f, e + 1);
        chk("busy_last_cycle", bsy[0], 1);
        @(negedge clk);
        chk("busy_fall", bsy[0], 0);

        // 7E1 / 7O1, 0x55: parity 0 / 1, frame 160 cycles
        push(1, 8'h55, e);
        rx_frame(1, f, pb);
        chk("even_par", pb, 0);
        chk("even_lat", f, e + 1);
        @(negedge clk);
        chk("even_busy_fall", bsy[1], 0);
        push(2, 8'h55, e);
        rx_frame(2, f, pb);
        chk("odd_par", pb, 1);
        @(negedge clk);
        chk("odd_busy_fall", bsy[2], 0);

        // 8N2 back-to-back 0xFF, 0x00: one idle cycle between frames
        fork
            begin push(3, 8'hFF, e1); push(3, 8'h00, e2); end
            begin rx_frame(3, f1, pb); rx_frame(3, f2, pb); end
        join
        chk("b2b_gap", f2 - f1, 177);
        @(negedge clk);
        chk("b2b_total", cyc - f1, 2 * (10 * BIT + BIT) + 1);
        chk("b2b_busy_fall", bsy[3], 0);

`ifdef UART_TX_STREAM_FIFO_EN
        // Depth 4: burst of 1..8 accepts 5, ready returns after the next pop
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    @(posedge clk); #1;
                    vld[0] = 1'b1;
                    dat[0] = 8'(k);
                    @(negedge clk);
                    if (rdy[0]) acc++;
                end
                @(posedge clk); #1;
                vld[0] = 1'b0;
                chk("burst_acc", acc, 5);
                chk("burst_full_rdy", rdy[0], 0);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (fc[0] == 3'd4 && n < BUDGET);
                chk("rdy_reassert", rdy[0], 1);
                chk("fc_after_pop", fc[0], 3);
            end
            begin
                for (int k = 0; k < 5; k++) rx_frame(0, f, pb);
            end
        join
        nbuf = 2;
`else
        // Holding register: second word accepted mid-frame, third waits
        fork
            begin push(0, 8'hA5, e1); push(0, 8'h3C, e2); push(0, 8'h0F, e3); end
            begin rx_frame(0, f1, pb); rx_frame(0, f2, pb); rx_frame(0, f3, pb); end
        join
        chk("hold_2nd_edge", e2, e1 + 2);
        chk("hold_2nd_in_frame", (e2 < f1 + 160) ? 1 : 0, 1);
        chk("hold_3rd_edge", e3, f2 + 1);
        chk("hold_f2_start", f2, f1 + 161);
        nbuf = 1;
`endif
        repeat (4) @(negedge clk);

        // Reset at cycle 50 of a frame with words buffered behind it
        push(0, 8'h11, e1);
        push(0, 8'h22, e);
`ifdef UART_TX_STREAM_FIFO_EN
        push(0, 8'h33, e);
`endif
        n = 0;
        while (cyc < e1 + 1 + 50 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_busy", bsy[0], 1);
        chk("pre_rst_cnt", fc[0], nbuf);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("mid_rst_tx", txv[0], 1);
        chk("mid_rst_fc", fc[0], 0);
        chk("mid_rst_busy", bsy[0], 0);
        chk("mid_rst_rdy", rdy[0], 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_rdy_rel", rdy[0], 1);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (txv[0] !== 1'b1) lows++;
        end
        chk("no_frame_after_rst", lows, 0);
        chk("idle_busy", bsy[0], 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter with an integrated baud-rate divider, valid/ready input handshake and transmit FIFO. It replaces the fixed 8N1 transmitter plus separate baud clock generator pair, and runs entirely in the system `clk` domain with no derived clocks. Data width, parity, stop bits, baud rate and buffer depth are parameters. It sits between on-chip sensor and data producers and the board UART pin.

## Interface
- `CLK_FREQ`, 12000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate. Bit period `DIV = CLK_FREQ / BAUD` (integer, truncated). `DIV >= 2` is required.
- `DATA_BITS`, 8: payload bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 8: FIFO entries, power of two, minimum 2. Used only with `UART_TX_STREAM_FIFO_EN`.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: producer offers `in_data`.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input DATA_BITS: payload, transmitted LSB first.
- `tx` output 1: serial line, idle high. Registered.
- `busy` output 1: frame in progress or data buffered.
- `fifo_count` output `$clog2(FIFO_DEPTH+1)`: words buffered and not yet started.

## Operation
- Handshake: a word is accepted on a rising edge where `in_valid && in_ready`. `in_data` need only be stable in that cycle.
- `in_ready = !full`, forced to 0 while `rst_n` is low.
- When the FIFO is full, `in_ready` stays 0 even if a pop happens in the same cycle. There is no push-through-on-pop.
- A push and a pop in the same cycle are legal when the FIFO is neither full nor empty. `fifo_count` is unchanged in that case.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
  - `IDLE`: `tx` = 1. If the FIFO is non-empty, pop into shift register, clear baud counter and bit index, go to `START`.
  - `START`: `tx` = 0 for DIV cycles, then go to `DATA`.
  - `DATA`: `tx` = shift[0] for DIV cycles, then shift right. After DATA_BITS bits, go to `PARITY` if PARITY != 0, else `STOP`.
  - `PARITY`: parity bit for DIV cycles. Odd parity makes the total count of ones (data plus parity) odd; even parity makes it even. Then go to `STOP`.
  - `STOP`: `tx` = 1 for STOP_BITS×DIV cycles, then go to `IDLE`.
- No bypass: a word pushed into an empty FIFO is popped on the following edge.
- Back-to-back frames: when the FIFO is non-empty at the end of `STOP`, `IDLE` lasts exactly 1 cycle before the next start bit.
- The baud counter counts 0..DIV-1 and restarts at every bit boundary, so no fractional accumulation occurs.
- `busy = (state != IDLE) || (fifo_count != 0)`.

## Timing
- Reset (`rst_n` low at an edge): `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=0, state=`IDLE`, FIFO pointers cleared. `in_ready` = 1 in the first cycle after `rst_n` returns high.
- Reset mid-frame truncates the frame: `tx` is 1 from that edge and buffered data is discarded.
- Handshake at edge N with an idle, empty block: `fifo_count`=1 after N, `tx` falls at edge N+1, `fifo_count`=0 after N+1.
- Frame length: `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV` cycles, from the falling edge of the start bit to the end of the last stop bit.
- `busy` deasserts at the edge where `STOP` returns to `IDLE`, provided the FIFO is empty.

## Configuration
- `UART_TX_STREAM_FIFO_EN` defined: FIFO of `FIFO_DEPTH` entries as described above.
- Not defined: single holding register replaces the FIFO and `FIFO_DEPTH` is ignored.
  - `in_ready` = 1 only when the holding register is empty.
  - `fifo_count` is 0 or 1.
  - The next word can be accepted while a frame shifts out.
  - Handshake, latency and frame timing are otherwise identical.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD`=1, so DIV=16.
- 8N1, push 0x2A at edge 10:
  - `tx` falls at edge 11.
  - Line pattern, 16 cycles per bit: 0,0,1,0,1,0,1,0,0,1.
  - `busy` falls at edge 171.
- `PARITY`=2, `DATA_BITS`=7, push 0x55: parity bit 0. With `PARITY`=1 the parity bit is 1. Frame is 160 cycles.
- `STOP_BITS`=2, push 0xFF then 0x00 back-to-back:
  - Stop high for 32 cycles.
  - Exactly 1 idle cycle, then the second start bit.
  - Total 2×(10×16+16)+1 cycles from first start to second frame end.
- FIFO (`FIFO_DEPTH`=4, macro defined): hold `in_valid` for 8 cycles with data 1..8.
  - 5 words are accepted (4 buffered plus 1 popped), then `in_ready`=0.
  - `in_ready` reasserts 1 cycle after the next pop.
  - Serial output is 1..5 in order.
- Drop `rst_n` at cycle 50 of a frame carrying a further 2 buffered words:
  - `tx`=1, `fifo_count`=0, `busy`=0 at the next edge.
  - No further frames are sent.
- Macro undefined: push 0xA5 and 0x3C.
  - Second word is accepted while the first frame shifts.
  - Third `in_valid` is held off until the second frame starts.
